// File: rtl/run_ctrl.sv
// Run sequencer for the single-cycle core: holds the core in reset, preloads dmem
// from a host write stream, releases the core, counts RUN cycles and stops on done/timeout.
module run_ctrl #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned MAX_CYC = 65535,
    parameter int unsigned HOLDOFF = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             host_valid,
    output logic             host_ready,
    input  logic [7:0]       host_addr,
    input  logic [7:0]       host_data,
    input  logic             host_last,
    output logic             core_rst,
    input  logic             core_done,
    output logic             dm_we,
    output logic [7:0]       dm_addr,
    output logic [7:0]       dm_di,
    output logic             busy,
    output logic             finished,
    output logic             timeout,
    output logic [CNT_W-1:0] cycles
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DONE,
        TMO
    } state_t;

    state_t state, state_nx;
    logic   accept;

    assign accept = host_valid && host_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (abort) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE, DONE, TMO: if (start) state_nx = LOAD;
                LOAD:            if (accept && host_last) state_nx = RUN;
                RUN: begin
                    // DONE takes precedence over a simultaneous budget expiry
                    if (core_done && cycles >= CNT_W'(HOLDOFF)) state_nx = DONE;
                    else if (cycles == CNT_W'(MAX_CYC))         state_nx = TMO;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // cycles is 0 only in the first RUN cycle, which doubles as the final-write cycle
    always_comb begin
        core_rst   = !(state == RUN && cycles != '0);
        host_ready = (state == LOAD);
        busy       = (state == LOAD) || (state == RUN);
        finished   = (state == DONE);
        timeout    = (state == TMO);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycles  <= '0;
            dm_we   <= 1'b0;
            dm_addr <= '0;
            dm_di   <= '0;
        end else begin
            dm_we <= accept && !abort;
            if (accept && !abort) begin
                dm_addr <= host_addr;
                dm_di   <= host_data;
            end
            if (state != LOAD && state_nx == LOAD)
                cycles <= '0;
            else if (state == RUN && state_nx == RUN)
                cycles <= cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_run_ctrl.sv
// Directed testbench for run_ctrl: preload, done, holdoff, timeout, abort and async reset.
module tb_run_ctrl;

    localparam int unsigned CNT_W = 16;

    // {core_rst, host_ready, busy, finished, timeout, dm_we}
    localparam logic [5:0] S_IDLE  = 6'b100000;
    localparam logic [5:0] S_LOAD  = 6'b111000;
    localparam logic [5:0] S_LDW   = 6'b111001;
    localparam logic [5:0] S_RUN0W = 6'b101001;
    localparam logic [5:0] S_RUN0  = 6'b101000;
    localparam logic [5:0] S_RUN   = 6'b001000;
    localparam logic [5:0] S_DONE  = 6'b100100;
    localparam logic [5:0] S_TO    = 6'b100010;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             host_valid = 1'b0;
    logic             host_ready;
    logic [7:0]       host_addr = '0;
    logic [7:0]       host_data = '0;
    logic             host_last = 1'b0;
    logic             core_rst;
    logic             core_done = 1'b0;
    logic             dm_we;
    logic [7:0]       dm_addr;
    logic [7:0]       dm_di;
    logic             busy;
    logic             finished;
    logic             timeout;
    logic [CNT_W-1:0] cycles;
    logic [5:0]       st;

    int n_cmp = 0;
    int n_err = 0;

    assign st = {core_rst, host_ready, busy, finished, timeout, dm_we};

    run_ctrl #(.CNT_W(CNT_W), .MAX_CYC(8), .HOLDOFF(2)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .host_valid(host_valid), .host_ready(host_ready), .host_addr(host_addr),
        .host_data(host_data), .host_last(host_last), .core_rst(core_rst),
        .core_done(core_done), .dm_we(dm_we), .dm_addr(dm_addr), .dm_di(dm_di),
        .busy(busy), .finished(finished), .timeout(timeout), .cycles(cycles)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // start from IDLE/DONE/TIMEOUT and push one last-marked word; ends in first RUN cycle
    task automatic run_one(input logic [7:0] a, input logic [7:0] d);
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++; if (st !== S_LOAD || cycles !== 16'd0) begin n_err++; $display("FAIL run_one_load st=%b/%b cycles=%0d/0", st, S_LOAD, cycles); end
        host_valid = 1'b1; host_addr = a; host_data = d; host_last = 1'b1;
        tick();
        host_valid = 1'b0; host_last = 1'b0;
        n_cmp++; if (st !== S_RUN0W || dm_addr !== a || dm_di !== d) begin n_err++; $display("FAIL run_one_run0 st=%b/%b addr=%h/%h di=%h/%h", st, S_RUN0W, dm_addr, a, dm_di, d); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (st !== S_IDLE || cycles !== 16'd0 || dm_addr !== 8'h00 || dm_di !== 8'h00) begin n_err++; $display("FAIL reset_vals st=%b/%b cycles=%0d addr=%h di=%h", st, S_IDLE, cycles, dm_addr, dm_di); end
        reset = 1'b0;
        host_valid = 1'b1;
        tick();
        host_valid = 1'b0;
        n_cmp++; if (st !== S_IDLE) begin n_err++; $display("FAIL idle_ignores_host st=%b/%b", st, S_IDLE); end
    endtask

    task automatic test_load();
        logic [7:0] addrs [3];
        logic [7:0] datas [3];
        logic [5:0] exp_st [3];
        addrs = '{8'h10, 8'h11, 8'h12};
        datas = '{8'hAA, 8'hBB, 8'hCC};
        exp_st = '{S_LDW, S_LDW, S_RUN0W};
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++; if (st !== S_LOAD || cycles !== 16'd0) begin n_err++; $display("FAIL load_entry st=%b/%b cycles=%0d/0", st, S_LOAD, cycles); end
        for (int i = 0; i < 3; i++) begin
            host_valid = 1'b1; host_addr = addrs[i]; host_data = datas[i]; host_last = (i == 2);
            tick();
            n_cmp++; if (st !== exp_st[i] || dm_addr !== addrs[i] || dm_di !== datas[i]) begin n_err++; $display("FAIL load_word%0d st=%b/%b addr=%h/%h di=%h/%h", i, st, exp_st[i], dm_addr, addrs[i], dm_di, datas[i]); end
        end
        host_valid = 1'b0; host_last = 1'b0;
        tick();
        n_cmp++; if (st !== S_RUN || cycles !== 16'd1) begin n_err++; $display("FAIL run_release st=%b/%b cycles=%0d/1", st, S_RUN, cycles); end
    endtask

    task automatic test_done();
        // at cycles=1; start and host traffic in RUN must be ignored
        start = 1'b1; host_valid = 1'b1; host_addr = 8'h55; host_data = 8'h66;
        tick();
        start = 1'b0; host_valid = 1'b0;
        n_cmp++; if (st !== S_RUN || cycles !== 16'd2) begin n_err++; $display("FAIL run_ignores_start st=%b/%b cycles=%0d/2", st, S_RUN, cycles); end
        repeat (3) tick();
        n_cmp++; if (cycles !== 16'd5) begin n_err++; $display("FAIL run_count cycles=%0d/5", cycles); end
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        n_cmp++; if (st !== S_DONE || cycles !== 16'd5) begin n_err++; $display("FAIL done_at5 st=%b/%b cycles=%0d/5", st, S_DONE, cycles); end
        repeat (2) tick();
        n_cmp++; if (st !== S_DONE || cycles !== 16'd5) begin n_err++; $display("FAIL done_sticky st=%b/%b cycles=%0d/5", st, S_DONE, cycles); end
    endtask

    task automatic test_holdoff();
        run_one(8'h20, 8'h55);
        core_done = 1'b1;
        tick();
        n_cmp++; if (st !== S_RUN0 && st !== S_RUN || busy !== 1'b1 || cycles !== 16'd1) begin n_err++; $display("FAIL holdoff_c1 st=%b cycles=%0d/1", st, cycles); end
        tick();
        n_cmp++; if (st !== S_RUN || cycles !== 16'd2) begin n_err++; $display("FAIL holdoff_c2 st=%b/%b cycles=%0d/2", st, S_RUN, cycles); end
        tick();
        core_done = 1'b0;
        n_cmp++; if (st !== S_DONE || cycles !== 16'd2) begin n_err++; $display("FAIL holdoff_done st=%b/%b cycles=%0d/2", st, S_DONE, cycles); end
    endtask

    task automatic test_timeout();
        run_one(8'h21, 8'h01);
        repeat (8) tick();
        n_cmp++; if (st !== S_RUN || cycles !== 16'd8) begin n_err++; $display("FAIL to_at_max st=%b/%b cycles=%0d/8", st, S_RUN, cycles); end
        tick();
        n_cmp++; if (st !== S_TO || cycles !== 16'd8) begin n_err++; $display("FAIL to_state st=%b/%b cycles=%0d/8", st, S_TO, cycles); end
        tick();
        n_cmp++; if (st !== S_TO || cycles !== 16'd8) begin n_err++; $display("FAIL to_sticky st=%b/%b cycles=%0d/8", st, S_TO, cycles); end
        // simultaneous done and budget expiry
        run_one(8'h22, 8'h02);
        repeat (8) tick();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        n_cmp++; if (st !== S_DONE || cycles !== 16'd8) begin n_err++; $display("FAIL tie_done st=%b/%b cycles=%0d/8", st, S_DONE, cycles); end
    endtask

    task automatic test_abort();
        start = 1'b1;
        tick();
        start = 1'b0;
        host_valid = 1'b1; host_addr = 8'h30; host_data = 8'h77; host_last = 1'b0;
        tick();
        n_cmp++; if (st !== S_LDW || dm_addr !== 8'h30 || dm_di !== 8'h77) begin n_err++; $display("FAIL abort_first_word st=%b/%b addr=%h/30 di=%h/77", st, S_LDW, dm_addr, dm_di); end
        abort = 1'b1; host_addr = 8'h31; host_data = 8'h88;
        tick();
        abort = 1'b0;
        n_cmp++; if (st !== S_IDLE) begin n_err++; $display("FAIL abort_idle st=%b/%b", st, S_IDLE); end
        repeat (2) tick();
        host_valid = 1'b0;
        n_cmp++; if (st !== S_IDLE || dm_addr !== 8'h30) begin n_err++; $display("FAIL abort_no_write st=%b/%b addr=%h/30", st, S_IDLE, dm_addr); end
    endtask

    task automatic test_reset_midrun();
        run_one(8'h40, 8'h99);
        repeat (4) tick();
        n_cmp++; if (st !== S_RUN || cycles !== 16'd4) begin n_err++; $display("FAIL midrun_pre st=%b/%b cycles=%0d/4", st, S_RUN, cycles); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (st !== S_IDLE || cycles !== 16'd0 || dm_addr !== 8'h00 || dm_di !== 8'h00) begin n_err++; $display("FAIL midrun_async st=%b/%b cycles=%0d addr=%h di=%h", st, S_IDLE, cycles, dm_addr, dm_di); end
        tick();
        reset = 1'b0;
        tick();
        run_one(8'h41, 8'h5A);
        repeat (3) tick();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        n_cmp++; if (st !== S_DONE || cycles !== 16'd3) begin n_err++; $display("FAIL rerun_done st=%b/%b cycles=%0d/3", st, S_DONE, cycles); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_done();
        test_holdoff();
        test_timeout();
        test_abort();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
